// File: rtl/hier_node_pkg.sv
// rtl/hier_node_pkg.sv - shared types and helpers for the hierarchy barrier node
package hier_node_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DISPATCH,
        WAIT,
        REPORT
    } state_e;

    localparam int MODE_PAR = 0;
    localparam int MODE_SEQ = 1;

    // Index width for a child count, never narrower than one bit.
    function automatic int clog2_safe(input int n);
        int w;
        w = 1;
        for (int i = 0; i < 31; i++) begin
            if ((1 << w) < n) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/hier_done_collector.sv
// rtl/hier_done_collector.sv - completion mask, child index, idle counter and spurious tracking
module hier_done_collector
    import hier_node_pkg::*;
#(
    parameter  int NUM_CHILDREN = 10,
    parameter  int TIMEOUT_W    = 16,
    localparam int IDX_W        = clog2_safe(NUM_CHILDREN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    window,
    input  logic                    mode,
    input  logic [TIMEOUT_W-1:0]    limit,
    input  logic [NUM_CHILDREN-1:0] child_done,
    output logic [NUM_CHILDREN-1:0] mask,
    output logic                    spurious,
    output logic [IDX_W-1:0]        next_idx,
    output logic                    all_done,
    output logic                    seq_step,
    output logic                    timeout_hit
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHILDREN - 1);

    logic [IDX_W-1:0]        idx;
    logic [TIMEOUT_W-1:0]    idle_cnt;
    logic [TIMEOUT_W-1:0]    idle_inc;
    logic [NUM_CHILDREN-1:0] sel;
    logic [NUM_CHILDREN-1:0] accept;
    logic [NUM_CHILDREN-1:0] mask_upd;
    logic                    any_accept;
    logic                    seq;

    always_comb begin
        seq        = (mode == 1'(MODE_SEQ));
        sel        = NUM_CHILDREN'(1) << idx;
        accept     = '0;
        if (window) begin
            accept = seq ? (child_done & sel) : (child_done & ~mask);
        end
        any_accept = |accept;
        mask_upd   = mask | accept;
        // Saturating increment so the counter can never wrap past the limit.
        idle_inc   = (&idle_cnt) ? idle_cnt : idle_cnt + TIMEOUT_W'(1);
        all_done   = seq ? (any_accept && idx == LAST_IDX) : (window && (&mask_upd));
        seq_step   = seq && any_accept && idx != LAST_IDX;
        timeout_hit = window && !any_accept && limit != '0 && idle_inc == limit;
        next_idx   = idx;
        if (clear) begin
            next_idx = '0;
        end else if (seq_step) begin
            next_idx = idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask     <= '0;
            spurious <= 1'b0;
            idx      <= '0;
            idle_cnt <= '0;
        end else begin
            mask     <= clear ? '0 : mask_upd;
            spurious <= (spurious && !clear) || (|(child_done & ~accept));
            idx      <= next_idx;
            if (clear || any_accept) begin
                idle_cnt <= '0;
            end else if (window && limit != '0) begin
                idle_cnt <= idle_inc;
            end
        end
    end

endmodule

// File: rtl/hier_node_barrier.sv
// rtl/hier_node_barrier.sv - tree barrier node: dispatch starts to children, collect dones, report upward
module hier_node_barrier
    import hier_node_pkg::*;
#(
    parameter int NUM_CHILDREN = 10,
    parameter int SEQ_MODE     = 0,
    parameter int TIMEOUT_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [TIMEOUT_W-1:0]    timeout_cycles_i,
    output logic [NUM_CHILDREN-1:0] child_start_o,
    input  logic [NUM_CHILDREN-1:0] child_done_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    timeout_o,
    output logic [NUM_CHILDREN-1:0] done_mask_o,
    output logic                    spurious_o
);

    localparam int   IDX_W = clog2_safe(NUM_CHILDREN);
    localparam logic SEQ   = (SEQ_MODE != MODE_PAR);

    state_e                  state;
    state_e                  state_next;
    logic                    start_ok;
    logic                    window;
    logic                    all_done;
    logic                    seq_step;
    logic                    timeout_hit;
    logic                    timeout_next;
    logic [IDX_W-1:0]        next_idx;
    logic [NUM_CHILDREN-1:0] child_start_next;

    assign start_ok = (state == IDLE) && start_i;
    assign window   = (state == WAIT);

    hier_done_collector #(
        .NUM_CHILDREN (NUM_CHILDREN),
        .TIMEOUT_W    (TIMEOUT_W)
    ) u_collector (
        .clk         (clk),
        .rst         (rst),
        .clear       (start_ok),
        .window      (window),
        .mode        (SEQ),
        .limit       (timeout_cycles_i),
        .child_done  (child_done_i),
        .mask        (done_mask_o),
        .spurious    (spurious_o),
        .next_idx    (next_idx),
        .all_done    (all_done),
        .seq_step    (seq_step),
        .timeout_hit (timeout_hit)
    );

    // Outputs are registered from the next state so each pulse lines up with its state.
    always_comb begin
        state_next   = state;
        timeout_next = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = DISPATCH;
                end
            end
            DISPATCH: state_next = WAIT;
            WAIT: begin
                if (all_done) begin
                    state_next = REPORT;
                end else if (seq_step) begin
                    state_next = DISPATCH;
                end else if (timeout_hit) begin
                    state_next   = REPORT;
                    timeout_next = 1'b1;
                end
            end
            REPORT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        child_start_next = '0;
        if (state_next == DISPATCH) begin
            child_start_next = SEQ ? (NUM_CHILDREN'(1) << next_idx) : '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            child_start_o <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            timeout_o     <= 1'b0;
        end else begin
            state         <= state_next;
            child_start_o <= child_start_next;
            busy_o        <= (state_next != IDLE);
            done_o        <= (state_next == REPORT);
            timeout_o     <= timeout_next;
        end
    end

endmodule

// File: doc/hier_node_barrier.md
Name: hier_node_barrier

Overview:
- Parametrised successor to the fixed 10-child, port-less hierarchy node.
- Instantiable at any level of the generated module tree with NUM_CHILDREN children.
- Receives a start request from its parent and dispatches start pulses to its children, either all at once (parallel) or one by one (sequential).
- Collects per-child completions with a timeout guard, then reports one done upward. Nodes compose into a tree-wide barrier.

Parameters:
- NUM_CHILDREN, 10, number of child ports (1..64).
- SEQ_MODE, 0, 0 = parallel dispatch, 1 = sequential dispatch in index order 0..N-1.
- TIMEOUT_W, 16, width of the timeout counter and of timeout_cycles_i.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  single-cycle start request from the parent.
- timeout_cycles_i  in  TIMEOUT_W  idle limit between completions; 0 disables the timeout.
- child_start_o  out  NUM_CHILDREN  one-cycle start pulse per child.
- child_done_i  in  NUM_CHILDREN  one-cycle completion pulse per child.
- busy_o  out  1  high from the cycle after an accepted start until the cycle after done_o.
- done_o  out  1  one-cycle completion pulse to the parent.
- timeout_o  out  1  pulses together with done_o when the run ended by timeout.
- done_mask_o  out  NUM_CHILDREN  children that completed in the current or last run.
- spurious_o  out  1  sticky flag for an unexpected or duplicate done; cleared on the next accepted start.

Behaviour:
- All outputs are registered.
- Reset values: child_start_o=0, busy_o=0, done_o=0, timeout_o=0, done_mask_o=0, spurious_o=0. FSM goes to IDLE and counters clear.
- FSM states: IDLE, DISPATCH, WAIT, REPORT.
- IDLE:
  - start_i=1 → DISPATCH. Clear done_mask_o, spurious_o, timeout counter and child index k.
  - start_i while not in IDLE is ignored (no queuing).
- DISPATCH (exactly 1 cycle):
  - child_start_o = all ones in parallel mode, or (1<<k) in sequential mode.
  - Next state is WAIT.
- WAIT, completion acceptance:
  - Parallel mode: child_done_i[j] is accepted only if done_mask_o[j]=0. It sets done_mask_o[j]. Multiple bits may be accepted in the same cycle.
  - Sequential mode: only bit k is accepted.
  - Any accepted done clears the timeout counter. Otherwise, if timeout_cycles_i≠0, the counter increments.
- WAIT, exits:
  - Parallel mode: mask all ones after the update → REPORT.
  - Sequential mode: after accepting child k, k<N-1 → k++, go to DISPATCH. k=N-1 → REPORT.
  - Timeout: counter reaches timeout_cycles_i → REPORT with the timeout flag set. Completion beats timeout when both occur in the same cycle.
- Spurious done: any child_done_i bit not accepted sets spurious_o. This covers IDLE, DISPATCH, REPORT, duplicates, and the wrong index in sequential mode. Spurious dones do not affect the mask or the FSM.
- REPORT (1 cycle):
  - done_o=1; timeout_o = timeout flag.
  - Next state is IDLE. busy_o drops in the following cycle.
  - done_mask_o holds until the next start.
- Latency, parallel mode, all children answering immediately:
  - start_i sampled at edge 0; child_start_o high in cycle 1.
  - Dones arriving in cycle 2 give done_o in cycle 3. Minimum start-to-done is 3 cycles.
- Latency, sequential mode: each child adds 2 cycles minimum (DISPATCH + WAIT).
- The timeout counter saturates and never wraps. Timeout is compared with equality at the counter width.
- rst mid-run aborts immediately. No done_o is generated and child_start_o is 0 on the next cycle.

Decomposition:
- hier_node_pkg holds:
  - state_e enum {IDLE, DISPATCH, WAIT, REPORT};
  - mode constants MODE_PAR=0, MODE_SEQ=1;
  - function clog2_safe for index width, minimum 1.
- Sub-module hier_done_collector:
  - contents: mask register, sequential index k, timeout counter, spurious logic;
  - inputs: accept window, mode, clear;
  - outputs: all_done, seq_step, timeout_hit.
- The top-level module keeps the FSM and output registers.

Test Plan:
- Parallel, N=10, timeout 0: start at cycle 0; all dones in cycle 2 → child_start_o=0x3FF in cycle 1, done_o in cycle 3, done_mask_o=0x3FF, timeout_o=0, spurious_o=0.
- Parallel, staggered: child j responds at cycle 2+j, and child 3 also pulses again at cycle 8 → done_o in cycle 12 and spurious_o=1.
- Sequential, N=4: each child answers 1 cycle after its start → child_start_o=1,2,4,8 in cycles 1,3,5,7; done_o in cycle 9; mask=0xF.
- Timeout, timeout_cycles_i=5: child 7 never answers, all others answer at cycle 2 → done_o and timeout_o together; mask=0x37F.
- start_i repeated during busy is ignored; a child done in IDLE → spurious_o=1, cleared by the next start.
- rst asserted in WAIT → all outputs return to reset values next cycle. A new start afterwards runs normally.
